bram_stream_reader: RTL and testbench
=====================================

Name: bram_stream_reader

Overview:
- Read-side master for the single-port-read, registered-output block RAM used in the FIR lab; the RAM has 1-cycle read latency and its read port is gated by re.
- On a start command, issues sequential reads from base_addr for len words.
- Returns the data as an AXI-Stream-style master stream with full backpressure support, sustaining one beat per cycle when m_tready is held high.
- Sits between a tap/data RAM and the FIR datapath or DMA consumer.

Parameters:
- ADDR_WIDTH, 13, RAM address width; len is ADDR_WIDTH+1 bits.
- BIT_WIDTH, 8, RAM word width and m_tdata width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  command strobe; accepted only when busy=0.
- base_addr  in  ADDR_WIDTH  first read address, sampled on start accept.
- len  in  ADDR_WIDTH+1  word count, sampled on start accept; 0 is legal.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- bram_re  out  1  RAM read enable.
- bram_raddr  out  ADDR_WIDTH  RAM read address.
- bram_rdo  in  BIT_WIDTH  RAM read data, valid the cycle after bram_re.
- m_tvalid  out  1  stream valid.
- m_tready  in  1  stream ready.
- m_tdata  out  BIT_WIDTH  stream data.
- m_tlast  out  1  marks the final beat.

Behaviour:
- Reset (async, rst_n=0):
  - busy, done, bram_re, m_tvalid and m_tlast are 0; bram_raddr and m_tdata are 0.
  - Skid FIFO is emptied, in-flight flag is cleared, state is IDLE.
  - Reset mid-transfer discards all data; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE: when start=1, latch addr=base_addr, remaining=len and beats_left=len. Go to RUN if len!=0, else DONE. busy=1 from the next cycle when len!=0.
  - RUN: issue reads and stream beats. When the handshake with m_tlast=1 occurs, go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
  - len=0 therefore gives a done pulse exactly one cycle after start, with no bram_re and no beats.
- start while busy or in DONE is ignored.
- Read issue:
  - count = skid FIFO occupancy (0..2) + in-flight read (0/1). pop = m_tvalid & m_tready.
  - bram_re=1 in a cycle iff state=RUN, remaining>0, and (count - pop) < 2.
  - bram_raddr=addr during that cycle. On issue: addr increments modulo 2^ADDR_WIDTH (0x1FFF wraps to 0x0000) and remaining decrements.
  - bram_re is combinational from state; bram_raddr holds its last value when re=0.
- Return path:
  - The in-flight flag is set on issue. bram_rdo is pushed into the 2-entry FIFO on the cycle after issue.
  - Overflow is impossible by the issue rule.
- Stream:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head; m_tlast = (beats_left==1) & m_tvalid.
  - beats_left decrements on each handshake.
  - m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0.
  - Order is strictly ascending address; no loss, no duplication.
- Latency:
  - First bram_re in the cycle after start accept; first m_tvalid 2 cycles after that.
  - With m_tready=1 throughout, beats are contiguous, one per cycle.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.

Optional Feature:
- Macro BRS_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt[15:0], which counts cycles with m_tvalid=1 & m_tready=0.
  - Saturates at 0xFFFF.
  - Cleared to 0 on start accept and on reset; holds its value after done.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- RAM[0..3]=10,11,12,13; base=0, len=4; m_tready=1 -> m_tdata 10,11,12,13 on 4 consecutive cycles; m_tlast only on 13; done 1 cycle after the last handshake; bram_re asserted exactly 4 times.
- len=0 -> bram_re never asserted, m_tvalid never asserted, busy stays 0, done pulses the cycle after start.
- len=8, base=0x20, RAM[i]=i; m_tready pattern 1,0,1,0,... -> beats 0x20..0x27 in order; bram_re never issues when count-pop=2; m_tdata stable during every stall.
- base=0x1FFE, len=4 -> bram_raddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001; 4 beats, m_tlast on the 4th.
- start pulsed mid-transfer -> ignored, output unchanged. rst_n=0 asynchronously mid-transfer -> m_tvalid, busy and bram_re go to 0 immediately. A new start (base=0, len=2) after release completes normally.
- BRS_STALL_CNT_EN defined; len=3; m_tready held low for 5 cycles after the first m_tvalid, then high -> stall_cnt=5 at done; stall_cnt=0 after the next start.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: sequential read master for a 1-cycle-latency registered
// block RAM. It streams the words out on an AXI-Stream-style master port and
// supports full backpressure.
// Optional build macro BRS_STALL_CNT_EN adds a saturating stall_cnt output.
// That counter counts the cycles in which the stream is stalled by the sink.
module bram_stream_reader #(
  parameter int ADDR_WIDTH = 13,
  parameter int BIT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_re,
  output logic [ADDR_WIDTH-1:0] bram_raddr,
  input  logic [BIT_WIDTH-1:0]  bram_rdo,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [BIT_WIDTH-1:0]  m_tdata,
  output logic                  m_tlast
`ifdef BRS_STALL_CNT_EN
  ,output logic [15:0]          stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]       addr, raddr_q;
  logic [ADDR_WIDTH:0]         remaining, beats_left;
  logic [1:0][BIT_WIDTH-1:0]   fifo;
  logic                        rd_ptr, wr_ptr;
  logic [1:0]                  occ;
  logic                        inflight;
  logic                        accept, issue, pop, push;
  logic [2:0]                  count;

  assign accept   = (state == S_IDLE) && start;
  assign pop      = m_tvalid && m_tready;
  assign push     = inflight;
  // Words already owed to the skid buffer: the stored ones plus the read in flight.
  assign count    = {1'b0, occ} + {2'b0, inflight};
  // A beat popped this cycle frees a slot, so the next read can still be issued.
  // This keeps the two-entry buffer from overflowing and sustains one beat per cycle.
  assign issue    = (state == S_RUN) && (remaining != '0) &&
                    ((count - {2'b0, pop}) < 3'd2);

  assign bram_re    = issue;
  assign bram_raddr = issue ? addr : raddr_q;
  assign busy       = (state == S_RUN);
  assign done       = (state == S_DONE);
  assign m_tvalid   = (occ != 2'd0);
  assign m_tdata    = fifo[rd_ptr];
  assign m_tlast    = m_tvalid && (beats_left == (ADDR_WIDTH+1)'(1));

  // Next-state logic: a zero-length command goes straight to the completion pulse.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (len != '0) ? S_RUN : S_DONE;
      S_RUN:  if (pop && m_tlast) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Command latch, read address/remaining counters and beat counter.
  // raddr_q keeps the last issued address on the RAM port while re is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr       <= '0;
      raddr_q    <= '0;
      remaining  <= '0;
      beats_left <= '0;
    end else if (accept) begin
      addr       <= base_addr;
      remaining  <= len;
      beats_left <= len;
    end else begin
      if (issue) begin
        addr      <= addr + ADDR_WIDTH'(1);
        raddr_q   <= addr;
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      if (pop) beats_left <= beats_left - (ADDR_WIDTH+1)'(1);
    end
  end

  // Return path: the in-flight flag marks RAM data arriving next cycle.
  // That data is captured into the two-entry skid FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      fifo     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      occ      <= 2'd0;
    end else begin
      inflight <= issue;
      if (push) begin
        fifo[wr_ptr] <= bram_rdo;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef BRS_STALL_CNT_EN
  // Sink-stall counter: saturating, cleared on each accepted command, held after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             stall_cnt <= 16'd0;
    else if (accept)                                        stall_cnt <= 16'd0;
    else if (m_tvalid && !m_tready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bench for bram_stream_reader.
// A RAM model feeds the DUT. A transfer-level reference (expected beat list,
// issue timing and outstanding-read bound) checks every cycle.
module tb_bram_stream_reader;
  logic        clk, rst_n, start, m_tready;
  logic [12:0] base_addr;
  logic [13:0] len;
  logic        busy, done, bram_re, m_tvalid, m_tlast;
  logic [12:0] bram_raddr;
  logic [7:0]  bram_rdo, m_tdata;
`ifdef BRS_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  bram_stream_reader #(.ADDR_WIDTH(13), .BIT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .bram_re(bram_re), .bram_raddr(bram_raddr),
    .bram_rdo(bram_rdo), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata),
`ifdef BRS_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .m_tlast(m_tlast));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered output, 1-cycle latency, gated by re.
  logic [7:0] mem [0:8191];
  initial bram_rdo = 8'd0;
  always @(posedge clk) if (bram_re) bram_rdo <= mem[bram_raddr];

  int checks = 0, errors = 0;
  int cyc = 0, issued = 0, popped = 0, xlen = 0, done_due = -10, re_cnt = 0, stall_model = 0;
  logic [12:0] xbase;
  bit          in_run = 0;
  int          iss_cyc[$];
  logic [7:0]  expq[$];
  bit          prev_stall = 0;
  logic [7:0]  prev_data;
  logic        prev_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the reference.
  task automatic step(input logic st, input logic rdy);
    bit ev, er, pop, acc;
    @(negedge clk);
    start = st; m_tready = rdy;
    #1;
    cyc++;
    ev  = in_run && (popped < issued) && (iss_cyc[popped] + 2 <= cyc);
    pop = ev && rdy;
    er  = in_run && (issued < xlen) && ((issued - popped - (pop ? 1 : 0)) < 2);
    chk("busy", busy, in_run);
    chk("done", done, cyc == done_due);
    chk("m_tvalid", m_tvalid, ev);
    chk("bram_re", bram_re, er);
    if (er) chk("bram_raddr", bram_raddr, 13'(xbase + issued));
    if (ev) begin
      chk("m_tdata", m_tdata, expq[popped]);
      chk("m_tlast", m_tlast, popped == xlen - 1);
    end else chk("m_tlast_idle", m_tlast, 1'b0);
    if (prev_stall) begin
      chk("stall_data", m_tdata, prev_data);
      chk("stall_last", m_tlast, prev_last);
    end
    prev_stall = m_tvalid && !rdy;
    prev_data  = m_tdata;
    prev_last  = m_tlast;
    if (ev && !rdy && stall_model < 65535) stall_model++;
    acc = st && !in_run && (cyc != done_due);
    if (bram_re === 1'b1) re_cnt++;
    if (er) begin iss_cyc.push_back(cyc); issued++; end
    if (pop) begin
      popped++;
      if (popped == xlen) begin in_run = 0; done_due = cyc + 1; end
    end
    if (acc) begin
      xbase = base_addr; xlen = int'(len); issued = 0; popped = 0;
      iss_cyc.delete(); expq.delete();
      for (int i = 0; i < xlen; i++) expq.push_back(mem[13'(base_addr + i)]);
      re_cnt = 0; stall_model = 0;
      if (xlen != 0) in_run = 1; else done_due = cyc + 1;
    end
  endtask

  function automatic logic pat(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      default: return !(k >= 3 && k <= 7);
    endcase
  endfunction

  // Full transfer: start, run until the reference sees done, then check totals.
  task automatic run_xfer(input int b, input int l, input int mode);
    int k;
    base_addr = 13'(b); len = 14'(l);
    step(1'b1, pat(mode, 0));
    k = 1;
    while ((in_run || cyc < done_due) && k < 4 * l + 20) begin
      step(1'b0, pat(mode, k));
`ifdef BRS_STALL_CNT_EN
      if (k == 1) chk("stall_clr", stall_cnt, 16'd0);
`endif
      k++;
    end
    chk("re_count", re_cnt, l);
`ifdef BRS_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stall_model);
`endif
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 8'(10 + i);
    for (int i = 0; i < 8; i++) mem[32 + i] = 8'(32 + i);
    rst_n = 1'b0; start = 1'b0; m_tready = 1'b0; base_addr = '0; len = '0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_re", bram_re, 1'b0);
    chk("rst_valid", m_tvalid, 1'b0);
    chk("rst_last", m_tlast, 1'b0);
    chk("rst_raddr", bram_raddr, 13'd0);
    chk("rst_tdata", m_tdata, 8'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_xfer(0, 4, 0);           // basic contiguous stream
    run_xfer(5, 0, 0);           // zero length
    run_xfer(32, 8, 1);          // alternating backpressure
    run_xfer(13'h1FFE, 4, 0);    // address wrap

    // start while busy is ignored, then asynchronous reset mid-transfer
    base_addr = 13'h100; len = 14'd8;
    step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
    base_addr = 13'h300; len = 14'd3;
    step(1'b1, 1'b1); step(1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", m_tvalid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_re", bram_re, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_raddr", bram_raddr, 13'd0);
    in_run = 0; done_due = -10; prev_stall = 0;
    iss_cyc.delete(); expq.delete(); issued = 0; popped = 0; xlen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run_xfer(0, 2, 0);

    for (int t = 0; t < 6; t++) run_xfer(int'($urandom_range(0, 8191)), int'($urandom_range(1, 20)), 2);
    run_xfer(100, 3, 3);         // 5 stalled cycles after first valid
    run_xfer(200, 2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
